// File: rtl/serializer_buf.sv
// Buffered parallel-to-serial converter: DEPTH-word FIFO feeding a gapless bit shifter.
// First serial bit two cycles after acceptance; data_rdy_o drops only while the FIFO is full.

module serializer_buf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic [W-1:0]            wdat,
    input  logic                    pop,
    output logic [W-1:0]            rdat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage is not reset; only pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdat = mem[rd_ptr];
endmodule

module serializer_buf #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int MIN_MOD = 1
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH):0]   data_mod_i,
    input  logic                     data_msb_first_i,
    input  logic                     data_val_i,
    output logic                     data_rdy_o,
    output logic                     ser_data_o,
    output logic                     ser_data_val_o,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int MW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WIDTH + MW + 1;

    localparam logic [MW-1:0] MOD_LO  = MW'(MIN_MOD);
    localparam logic [MW-1:0] MOD_HI  = MW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            accept;
    logic            legal;
    logic            push;
    logic            pop;
    logic            last;
    logic [EW-1:0]   head;
    logic [WIDTH-1:0] head_word;
    logic [MW-1:0]   head_mod;
    logic            head_msb;
    logic [WIDTH-1:0] shreg;
    logic [MW-1:0]   bit_cnt;
    logic            msb_q;
    logic            busy_q;
    logic            err_q;

    assign legal  = (data_mod_i >= MOD_LO) && (data_mod_i <= MOD_HI);
    assign accept = data_val_i && data_rdy_o;
    assign push   = accept && legal;

    serializer_buf_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .srst  (srst_i),
        .push  (push),
        .wdat  ({data_msb_first_i, data_mod_i, data_i}),
        .pop   (pop),
        .rdat  (head),
        .count (count)
    );

    assign {head_msb, head_mod, head_word} = head;
    assign data_rdy_o = (count != DEPTH_C);

    // A new word is loaded either from idle or on the last bit of the current one.
    assign last = (state == SHIFT) && (bit_cnt == MW'(1));
    assign pop  = (count != '0) && ((state == IDLE) || last);
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = SHIFT;
            SHIFT:   if (last && !pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ser_data_val_o = (state == SHIFT);
        ser_data_o     = ser_data_val_o && (msb_q ? shreg[WIDTH-1] : shreg[0]);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
            msb_q   <= 1'b0;
        end else if (pop) begin
            shreg   <= head_word;
            bit_cnt <= head_mod;
            msb_q   <= head_msb;
        end else if (state == SHIFT) begin
            shreg   <= msb_q ? (shreg << 1) : (shreg >> 1);
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Busy is computed from next-cycle state so it falls together with ser_data_val_o.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (count_nxt != '0) || (state_nxt == SHIFT);
            err_q  <= accept && !legal;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;
endmodule

// File: tb/tb_serializer_buf.sv
// Bench for serializer_buf: per-cycle comparison against a timeline model of the serial line.
module tb_serializer_buf;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int MIN_MOD = 1;
    localparam int MAXC    = 4096;
    localparam int HMAX    = 8192;

    logic        clk = 1'b0;
    logic        srst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic [4:0]  data_mod_i = '0;
    logic        data_msb_first_i = 1'b0;
    logic        data_val_i = 1'b0;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;
    logic        err_o;

    serializer_buf #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .MIN_MOD (MIN_MOD)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_mod_i       (data_mod_i),
        .data_msb_first_i (data_msb_first_i),
        .data_val_i       (data_val_i),
        .data_rdy_o       (data_rdy_o),
        .ser_data_o       (ser_data_o),
        .ser_data_val_o   (ser_data_val_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line timeline, indexed by cycle number.
    bit exp_val  [MAXC];
    bit exp_bit  [MAXC];
    bit exp_busy [MAXC];
    bit exp_err  [MAXC];
    int exp_occ  [MAXC];
    int line_free = 0;
    int last_acc  = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int tot_v = 0, err_tot = 0, busy_tot = 0, busy_fall = 0, rdy_low_tot = 0;
    bit prev_busy = 1'b0;
    int hist_cyc [HMAX];
    bit hist_bit [HMAX];

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int bits(input int b0, input int n);
        int v = 0;
        for (int i = 0; i < n; i++)
            if (b0 + i < HMAX) v = (v << 1) | int'(hist_bit[b0 + i]);
        return v;
    endfunction

    // Compare DUT against the model, record observations, then fold this cycle's inputs into the model.
    initial begin : cmp
        int m;
        int start;
        logic [4:0] act;
        logic [4:0] expv;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                expv = {exp_occ[cyc] != DEPTH, exp_val[cyc], exp_val[cyc] & exp_bit[cyc],
                        exp_busy[cyc], exp_err[cyc]};
                act  = {data_rdy_o, ser_data_val_o, ser_data_o, busy_o, err_o};
                n_tests++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL cycle_%0d outputs {rdy,val,dat,busy,err} got %b want %b", cyc, act, expv);
                end
                if (ser_data_val_o === 1'b1 && tot_v < HMAX) begin
                    hist_cyc[tot_v] = cyc;
                    hist_bit[tot_v] = ser_data_o;
                    tot_v++;
                end
                err_tot  += int'(err_o);
                busy_tot += int'(busy_o);
                if (data_rdy_o === 1'b0) rdy_low_tot++;
                if (prev_busy && !busy_o) busy_fall = cyc;
                prev_busy = busy_o;

                if (srst_i) begin
                    for (int k = cyc + 1; k < MAXC; k++) begin
                        exp_val[k] = 0; exp_bit[k] = 0; exp_busy[k] = 0;
                        exp_err[k] = 0; exp_occ[k] = 0;
                    end
                    line_free = 0;
                end else if (data_val_i && exp_occ[cyc] != DEPTH) begin
                    last_acc = cyc;
                    m = int'(data_mod_i);
                    if (m < MIN_MOD || m > WIDTH) begin
                        if (cyc + 1 < MAXC) exp_err[cyc + 1] = 1;
                    end else begin
                        start = (cyc + 2 > line_free) ? cyc + 2 : line_free;
                        for (int i = 0; i < m; i++)
                            if (start + i < MAXC) begin
                                exp_val[start + i] = 1;
                                exp_bit[start + i] = data_msb_first_i ? data_i[WIDTH-1-i] : data_i[i];
                            end
                        for (int k = cyc + 1; k < start + m && k < MAXC; k++) exp_busy[k] = 1;
                        for (int k = cyc + 1; k < start && k < MAXC; k++) exp_occ[k]++;
                        line_free = start + m;
                    end
                end
            end
        end
    end

    task automatic push(input logic [15:0] d, input int m, input bit msb);
        int t = 0;
        @(posedge clk); #1;
        data_i = d; data_mod_i = 5'(m); data_msb_first_i = msb; data_val_i = 1'b1;
        @(negedge clk);
        while (!data_rdy_o && t < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            data_val_i = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        data_val_i = 1'b0; srst_i = 1'b1;
        @(posedge clk); #1;
        srst_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : drive
        int b0, e0, v0, z0, acc, t, m;
        repeat (3) @(posedge clk);
        #1 srst_i = 1'b0;
        idle(2);

        // Single MSB-first word
        b0 = tot_v;
        push(16'hA5C3, 16, 1'b1);
        idle(24);
        acc = last_acc;
        chk("t1_latency", hist_cyc[b0] - acc, 2);
        chk("t1_count", tot_v - b0, 16);
        chk("t1_bits", bits(b0, 16), 'hA5C3);
        chk("t1_busy_fall", busy_fall - acc, 18);

        // LSB-first partial word
        b0 = tot_v;
        push(16'h00B5, 5, 1'b0);
        idle(12);
        chk("t2_count", tot_v - b0, 5);
        chk("t2_bits", bits(b0, 5), 'b10101);

        // Back-to-back mixed words
        b0 = tot_v;
        push(16'hD000, 4, 1'b1);
        push(16'h0055, 7, 1'b0);
        push(16'h1234, 16, 1'b1);
        idle(35);
        chk("t3_count", tot_v - b0, 27);
        chk("t3_span", hist_cyc[b0 + 26] - hist_cyc[b0] + 1, 27);
        chk("t3_bits", bits(b0, 27), 32'h06D51234);

        // Overfill with valid held high
        b0 = tot_v; z0 = rdy_low_tot;
        for (int i = 0; i < DEPTH + 2; i++) push(16'hC300 + 16'(i), 16, 1'b1);
        idle(110);
        chk("t4_count", tot_v - b0, 16 * (DEPTH + 2));
        chk("t4_rdy_dropped", int'(rdy_low_tot > z0), 1);
        for (int i = 0; i < DEPTH + 2; i++) chk("t4_word_order", bits(b0 + 16 * i, 16), 'hC300 + i);

        // Illegal bit counts
        e0 = err_tot; v0 = tot_v; z0 = busy_tot;
        push(16'hFFFF, 0, 1'b1);
        idle(3);
        push(16'hFFFF, 17, 1'b0);
        idle(5);
        chk("t5_err_pulses", err_tot - e0, 2);
        chk("t5_no_output", tot_v - v0, 0);
        chk("t5_no_busy", busy_tot - z0, 0);
        b0 = tot_v;
        push(16'h8001, 3, 1'b1);
        idle(10);
        chk("t5_legal_count", tot_v - b0, 3);
        chk("t5_legal_bits", bits(b0, 3), 'b100);

        // Reset while shifting with words queued
        b0 = tot_v;
        push(16'hF0F0, 16, 1'b1);
        push(16'hAAAA, 16, 1'b1);
        push(16'h5555, 16, 1'b1);
        idle(1);
        t = 0;
        while (tot_v - b0 < 6 && t < 100) begin @(negedge clk); t++; end
        chk("t6_reached_bit6", int'(t < 100), 1);
        pulse_reset();
        v0 = tot_v;
        idle(40);
        chk("t6_no_output_after_reset", tot_v - v0, 0);
        b0 = tot_v;
        push(16'h8000, 1, 1'b1);
        idle(5);
        acc = last_acc;
        chk("t6_new_latency", hist_cyc[b0] - acc, 2);
        chk("t6_new_bits", bits(b0, 1), 1);

        // Random traffic with occasional illegal words and resets
        for (int n = 0; n < 150 && cyc < 3600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) m = ($urandom_range(0, 1) == 1) ? 0 : 17;
                else m = int'($urandom_range(1, 16));
                push(16'($urandom), m, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
            end
        end
        idle(120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serializer_buf.md
# serializer_buf

Parametrised, buffered successor to the team's single-word serializer. It accepts parallel words with a per-word bit count and bit-order mode through a valid/ready handshake and queues them in a DEPTH-entry word FIFO. It then emits them as a continuous serial bit stream with no idle cycles between queued words. It sits between a parallel producer (packetiser, register bank) and a serial line driver.

## Interface
Parameters:
- WIDTH, 16, parallel word width in bits (>= 2)
- DEPTH, 4, word FIFO depth in entries (power of 2, >= 2)
- MIN_MOD, 1, smallest legal per-word bit count (1..WIDTH)

Ports:
- clk_i  in  1  clock; all logic is on the rising edge
- srst_i  in  1  reset, synchronous, active-high
- data_i  in  WIDTH  parallel word
- data_mod_i  in  $clog2(WIDTH)+1  number of bits of data_i to transmit
- data_msb_first_i  in  1  1: send from bit WIDTH-1 downward; 0: send from bit 0 upward
- data_val_i  in  1  word valid
- data_rdy_o  out  1  FIFO can take a word (FIFO not full)
- ser_data_o  out  1  serial bit
- ser_data_val_o  out  1  ser_data_o is valid this cycle
- busy_o  out  1  a word is buffered or being shifted
- err_o  out  1  one-cycle pulse: an accepted word had an illegal data_mod_i and was dropped

## Operation
- Handshake: a word is accepted on a cycle where data_val_i && data_rdy_o. data_i, data_mod_i and data_msb_first_i are sampled together on that cycle. When data_rdy_o is 0, data_val_i is ignored, with no side effects.
- Legality: data_mod_i is legal if MIN_MOD <= data_mod_i <= WIDTH.
  - An accepted illegal word is not written to the FIFO.
  - err_o goes to 1 on the next cycle, for exactly one cycle.
- FIFO: DEPTH entries, each holding {word, mod, msb_first}. The occupancy counter is $clog2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH. A simultaneous push and pop leaves the count unchanged.
- data_rdy_o = (count != DEPTH). It is combinational from registered state and does not depend on data_val_i.
- Shifter: a word register plus a remaining-bit counter of $clog2(WIDTH)+1 bits. States:
  - IDLE. Transition IDLE->SHIFT when the FIFO is non-empty: pop the head word and load it.
  - SHIFT: one bit per cycle.
    - MSB-first mode shifts left and takes bit WIDTH-1.
    - LSB-first mode shifts right and takes bit 0.
    - The counter decrements each cycle.
  - On the last bit, if the FIFO is non-empty, pop and load the next word on the same edge and stay in SHIFT (back-to-back). Otherwise go to IDLE.
- Only the low data_mod_i bits (LSB-first) or the high data_mod_i bits (MSB-first) are transmitted. Other bits are ignored.
- busy_o = (count != 0) || (state == SHIFT) || ser_data_val_o, registered so that it drops on the same cycle ser_data_val_o drops.
- ser_data_o is 0 whenever ser_data_val_o is 0.

## Timing
- Reset values: data_rdy_o=1 (one cycle after srst_i deasserts, since count=0), ser_data_o=0, ser_data_val_o=0, busy_o=0, err_o=0. The FIFO is emptied and the shifter goes to IDLE.
- Reset mid-operation: the stream is cut the cycle after srst_i is sampled high. Partial words and buffered words are discarded, with no flush.
- Latency: a word accepted on cycle N into an empty block gives its first ser_data_val_o on cycle N+2.
- A word with mod M holds ser_data_val_o high for exactly M consecutive cycles.
- Queued words are gapless: the last bit of word k is immediately followed by the first bit of word k+1.
- err_o is asserted on cycle N+1 for an illegal word accepted on cycle N.
- A push while full cannot occur, because data_rdy_o is low.
- Throughput: sustained acceptance is one word per M cycles once the FIFO is full.

## Test plan
- Single word, WIDTH=16: data_i=16'hA5C3, mod=16, msb_first=1, accepted on cycle 0. Required: ser_data_val_o high on cycles 2..17; bits 1010_0101_1100_0011; busy_o falls on cycle 18.
- LSB-first partial word: data_i=16'h00B5, mod=5, msb_first=0. Required: bits 1,0,1,0,1 on 5 consecutive valid cycles; upper bits are never emitted.
- Back-to-back: 3 words (mod 4, 7, 16) pushed on consecutive cycles. Required: ser_data_val_o continuously high for 27 cycles with no gap; per-word bit order correct.
- Full FIFO: push DEPTH+2 words of mod=16 every cycle with data_val_i held high. Required: data_rdy_o drops once count==DEPTH; no word is lost or duplicated; all DEPTH+2 words are emitted in order.
- Illegal mod: mod=0, then mod=WIDTH+1 (MIN_MOD=1). Required: one err_o pulse each on the next cycle; no serial output; busy_o stays 0; a following legal word is sent normally.
- Reset mid-word: srst_i high for 1 cycle while shifting bit 6 of a 16-bit word with 2 words queued. Required: next cycle ser_data_val_o=0, busy_o=0, data_rdy_o=1 and nothing else is emitted; a new word afterwards is sent with 2-cycle latency.
